ysyx_24110015_arbiter: RTL and testbench

Two-to-one AXI-lite arbiter between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write), feeding the single master port of the address-decoding crossbar. It serialises transactions: exactly one outstanding transaction system-wide, granted by round-robin on contention. Address/data fields pass through combinationally; only handshake signals are gated by the grant state.

---
 rtl/axi_lite_if.sv | 67 ++++++
 rtl/ysyx_24110015_arbiter.sv | 127 ++++++++++++
 tb/tb_ysyx_24110015_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// ============================================================================
//  Module      : axi_lite_if
//  Description : AXI-lite style bundle, 32-bit address/data, single beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_24110015_arbiter.sv
// ============================================================================
//  Module      : ysyx_24110015_arbiter
//  Description : Round-robin IFU/LSU arbiter, one outstanding AXI-lite txn.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24110015_arbiter (
    input  logic       clk,
    input  logic       rst,
    axi_lite_if.slave  ifu,
    axi_lite_if.slave  lsu,
    axi_lite_if.master out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFU_RD = 2'd1,
        S_LSU_RD = 2'd2,
        S_LSU_WR = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_grant;
    logic   w_last_grant_nxt;

    logic w_ifu_req;
    logic w_lsu_req;
    logic w_ifu_rd;
    logic w_lsu_rd;
    logic w_lsu_wr;
    logic w_r_done;
    logic w_b_done;
    logic w_unused;

    assign w_ifu_req = ifu.arvalid;
    assign w_lsu_req = lsu.arvalid | lsu.awvalid;
    assign w_ifu_rd  = (r_state == S_IFU_RD);
    assign w_lsu_rd  = (r_state == S_LSU_RD);
    assign w_lsu_wr  = (r_state == S_LSU_WR);
    assign w_r_done  = out.rvalid & out.rready;
    assign w_b_done  = out.bvalid & out.bready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // On a tie the master that did not win last time is chosen; an LSU
    // holding both AR and AW goes to the read first.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_ifu_req && (!w_lsu_req || r_last_grant)) begin
                    w_state_nxt      = S_IFU_RD;
                    w_last_grant_nxt = 1'b0;
                end else if (w_lsu_req) begin
                    w_state_nxt      = lsu.arvalid ? S_LSU_RD : S_LSU_WR;
                    w_last_grant_nxt = 1'b1;
                end
            end
            S_IFU_RD, S_LSU_RD: begin
                if (w_r_done) w_state_nxt = S_IDLE;
            end
            S_LSU_WR: begin
                if (w_b_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign out.arvalid = (w_ifu_rd & ifu.arvalid) | (w_lsu_rd & lsu.arvalid);
    assign ifu.arready = w_ifu_rd & out.arready;
    assign lsu.arready = w_lsu_rd & out.arready;
    assign out.rready  = (w_ifu_rd & ifu.rready) | (w_lsu_rd & lsu.rready);
    assign ifu.rvalid  = w_ifu_rd & out.rvalid;
    assign lsu.rvalid  = w_lsu_rd & out.rvalid;

    assign out.araddr  = w_ifu_rd ? ifu.araddr  : lsu.araddr;
    assign out.arid    = w_ifu_rd ? ifu.arid    : lsu.arid;
    assign out.arlen   = w_ifu_rd ? ifu.arlen   : lsu.arlen;
    assign out.arsize  = w_ifu_rd ? ifu.arsize  : lsu.arsize;
    assign out.arburst = w_ifu_rd ? ifu.arburst : lsu.arburst;

    assign out.awvalid = w_lsu_wr & lsu.awvalid;
    assign lsu.awready = w_lsu_wr & out.awready;
    assign out.wvalid  = w_lsu_wr & lsu.wvalid;
    assign lsu.wready  = w_lsu_wr & out.wready;
    assign lsu.bvalid  = w_lsu_wr & out.bvalid;
    assign out.bready  = w_lsu_wr & lsu.bready;

    assign out.awaddr  = lsu.awaddr;
    assign out.awid    = lsu.awid;
    assign out.awlen   = lsu.awlen;
    assign out.awsize  = lsu.awsize;
    assign out.awburst = lsu.awburst;
    assign out.wdata   = lsu.wdata;
    assign out.wstrb   = lsu.wstrb;
    assign out.wlast   = lsu.wlast;

    assign ifu.rdata   = out.rdata;
    assign ifu.rresp   = out.rresp;
    assign lsu.rdata   = out.rdata;
    assign lsu.rresp   = out.rresp;
    assign ifu.bresp   = out.bresp;
    assign lsu.bresp   = out.bresp;

    // The IFU is read-only: its write channels are never granted.
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;

    assign w_unused = ^{ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize, ifu.awburst,
                        ifu.awvalid, ifu.wdata, ifu.wstrb, ifu.wlast, ifu.wvalid,
                        ifu.bready};

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110015_arbiter.sv
// ============================================================================
//  Module      : tb_ysyx_24110015_arbiter
//  Description : Self-checking bench with master/slave models and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_24110015_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_if ifu_if ();
    axi_lite_if lsu_if ();
    axi_lite_if out_if ();

    ysyx_24110015_arbiter dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_if),
        .lsu (lsu_if),
        .out (out_if)
    );

    typedef struct {
        int               n_ifu;
        int               n_lr;
        int               n_lw;
        int               n_exp;
        logic [5:0][1:0]  exp;
    } vec_t;

    typedef struct {
        int code;
        int cyc;
        int gap;
    } gnt_t;

    // grant codes: 0 = IFU read, 1 = LSU read, 2 = LSU write
    vec_t        vecs [8];
    gnt_t        glog [$];
    logic [31:0] ifu_q [$];
    logic [31:0] lsu_rq [$];
    logic [63:0] lsu_wq [$];
    logic [31:0] ifu_exp [$];
    logic [31:0] lsu_exp [$];
    logic [67:0] aw_exp [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -100;
    int pres_cyc = -1;
    int cur_rd = -1;
    int wn = 0;

    bit ifu_busy, lsu_rbusy, lsu_wbusy;
    bit sl_rd, sl_wr, sl_block;
    int sl_bcnt;
    logic [31:0] sl_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h3000_0000) ? 32'h0000_0013 : (a ^ 32'hA5A5_5A5A);
    endfunction

    function automatic vec_t mk(input int ni, input int nr, input int nw, input int n,
                                input int e0, input int e1, input int e2,
                                input int e3, input int e4, input int e5);
        vec_t v;
        v.n_ifu = ni; v.n_lr = nr; v.n_lw = nw; v.n_exp = n;
        v.exp[0] = 2'(e0); v.exp[1] = 2'(e1); v.exp[2] = 2'(e2);
        v.exp[3] = 2'(e3); v.exp[4] = 2'(e4); v.exp[5] = 2'(e5);
        return v;
    endfunction

    function automatic bit all_idle();
        return !ifu_busy && !lsu_rbusy && !lsu_wbusy &&
               ifu_q.size() == 0 && lsu_rq.size() == 0 && lsu_wq.size() == 0;
    endfunction

    task automatic apply_slave();
        out_if.arready = !sl_rd && !sl_wr && !sl_block;
        out_if.rvalid  = sl_rd;
        out_if.rdata   = rdata_of(sl_addr);
        out_if.awready = !sl_rd && !sl_wr;
        out_if.wready  = !sl_rd && !sl_wr;
        out_if.bvalid  = sl_wr && (sl_bcnt == 0);
    endtask

    task automatic tick();
        bit f_iar, f_lar, f_law, f_lw, f_ir, f_lr, f_b;
        logic [67:0] e;
        @(negedge clk);
        cyc++;
        f_iar = ifu_if.arvalid & ifu_if.arready;
        f_lar = lsu_if.arvalid & lsu_if.arready;
        f_law = lsu_if.awvalid & lsu_if.awready;
        f_lw  = lsu_if.wvalid  & lsu_if.wready;
        f_ir  = ifu_if.rvalid  & ifu_if.rready;
        f_lr  = lsu_if.rvalid  & lsu_if.rready;
        f_b   = lsu_if.bvalid  & lsu_if.bready;

        check("ifu_wr_tied", 32'({ifu_if.awready, ifu_if.wready, ifu_if.bvalid}), 0);
        check("b_gate", 32'(lsu_if.bvalid & ~out_if.bvalid), 0);
        check("rd_excl_wr", 32'((out_if.arvalid | sl_rd) & (out_if.awvalid | out_if.wvalid)), 0);
        check("r_excl", 32'(ifu_if.rvalid & lsu_if.rvalid), 0);

        if (out_if.arvalid && out_if.arready) begin
            check("ar_onehot", 32'(ifu_if.arready) + 32'(lsu_if.arready), 1);
            cur_rd = ifu_if.arready ? 0 : 1;
            check("araddr", out_if.araddr, (cur_rd == 0) ? ifu_if.araddr : lsu_if.araddr);
            glog.push_back('{cur_rd, cyc, cyc - last_done});
            sl_rd   = 1'b1;
            sl_addr = out_if.araddr;
        end
        if (out_if.awvalid && out_if.awready) begin
            check("w_with_aw", 32'(out_if.wvalid & out_if.wready), 1);
            check("lsu_awready", 32'(lsu_if.awready), 1);
            if (aw_exp.size() == 0) begin
                check("aw_unexpected", 1, 0);
            end else begin
                e = aw_exp.pop_front();
                check("awaddr", out_if.awaddr, e[67:36]);
                check("wdata", out_if.wdata, e[35:4]);
                check("wstrb", 32'(out_if.wstrb), 32'(e[3:0]));
            end
            glog.push_back('{2, cyc, cyc - last_done});
            sl_wr   = 1'b1;
            sl_bcnt = 3;
        end else if (sl_wr && sl_bcnt > 0) begin
            sl_bcnt--;
        end
        if (out_if.rvalid && out_if.rready) begin
            check("r_onehot", 32'(ifu_if.rvalid) + 32'(lsu_if.rvalid), 1);
            if (ifu_if.rvalid) begin
                check("r_master_ifu", cur_rd, 0);
                if (ifu_exp.size() > 0) check("ifu_rdata", ifu_if.rdata, ifu_exp.pop_front());
                else check("ifu_r_unexpected", 1, 0);
            end else if (lsu_if.rvalid) begin
                check("r_master_lsu", cur_rd, 1);
                if (lsu_exp.size() > 0) check("lsu_rdata", lsu_if.rdata, lsu_exp.pop_front());
                else check("lsu_r_unexpected", 1, 0);
            end
            last_done = cyc;
            sl_rd = 1'b0;
        end
        if (out_if.bvalid && out_if.bready) begin
            check("b_fwd", 32'(lsu_if.bvalid), 1);
            last_done = cyc;
            sl_wr = 1'b0;
        end

        @(posedge clk);
        #1;
        apply_slave();
        if (f_iar) ifu_if.arvalid = 1'b0;
        if (f_ir)  ifu_busy = 1'b0;
        if (!ifu_busy && ifu_q.size() > 0) begin
            ifu_if.araddr  = ifu_q.pop_front();
            ifu_if.arvalid = 1'b1;
            ifu_busy       = 1'b1;
            ifu_exp.push_back(rdata_of(ifu_if.araddr));
            if (pres_cyc < 0) pres_cyc = cyc + 1;
        end
        if (f_lar) lsu_if.arvalid = 1'b0;
        if (f_lr)  lsu_rbusy = 1'b0;
        if (!lsu_rbusy && lsu_rq.size() > 0) begin
            lsu_if.araddr  = lsu_rq.pop_front();
            lsu_if.arvalid = 1'b1;
            lsu_rbusy      = 1'b1;
            lsu_exp.push_back(rdata_of(lsu_if.araddr));
            if (pres_cyc < 0) pres_cyc = cyc + 1;
        end
        if (f_law) lsu_if.awvalid = 1'b0;
        if (f_lw)  lsu_if.wvalid  = 1'b0;
        if (f_b)   lsu_wbusy = 1'b0;
        if (!lsu_wbusy && lsu_wq.size() > 0) begin
            e = {lsu_wq.pop_front(), 4'hF};
            lsu_if.awaddr  = e[67:36];
            lsu_if.wdata   = e[35:4];
            lsu_if.wstrb   = 4'hF;
            lsu_if.awvalid = 1'b1;
            lsu_if.wvalid  = 1'b1;
            lsu_wbusy      = 1'b1;
            aw_exp.push_back(e);
            if (pres_cyc < 0) pres_cyc = cyc + 1;
        end
    endtask

    task automatic run_until_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = all_idle();
        end
        check("timeout", 32'(done), 1);
    endtask

    task automatic push_write();
        lsu_wq.push_back({32'h8000_0100 + 32'(16 * wn), 32'hDEAD_BEEF ^ 32'(wn)});
        wn++;
    endtask

    task automatic run_vec(input vec_t v);
        glog.delete();
        pres_cyc = -1;
        for (int i = 0; i < v.n_ifu; i++) ifu_q.push_back(32'h3000_0000 + 32'(4 * i));
        for (int i = 0; i < v.n_lr; i++)  lsu_rq.push_back(32'h0200_BFF8 + 32'(8 * i));
        for (int i = 0; i < v.n_lw; i++)  push_write();
        run_until_idle();
        check("n_grants", glog.size(), v.n_exp);
        for (int k = 0; k < v.n_exp && k < glog.size(); k++) begin
            check("grant_order", glog[k].code, 32'(v.exp[k]));
            if (k == 0) check("grant_latency", glog[0].cyc, pres_cyc + 1);
            else        check("bubble", glog[k].gap, 2);
        end
    endtask

    initial begin
        ifu_if.araddr = '0; ifu_if.arid = '0; ifu_if.arlen = '0; ifu_if.arsize = 3'd2;
        ifu_if.arburst = 2'd1; ifu_if.arvalid = 1'b0; ifu_if.rready = 1'b1;
        ifu_if.awaddr = '0; ifu_if.awid = '0; ifu_if.awlen = '0; ifu_if.awsize = '0;
        ifu_if.awburst = '0; ifu_if.awvalid = 1'b0; ifu_if.wdata = '0; ifu_if.wstrb = '0;
        ifu_if.wlast = 1'b0; ifu_if.wvalid = 1'b0; ifu_if.bready = 1'b0;
        lsu_if.araddr = '0; lsu_if.arid = 4'd1; lsu_if.arlen = '0; lsu_if.arsize = 3'd2;
        lsu_if.arburst = 2'd1; lsu_if.arvalid = 1'b0; lsu_if.rready = 1'b1;
        lsu_if.awaddr = '0; lsu_if.awid = 4'd1; lsu_if.awlen = '0; lsu_if.awsize = 3'd2;
        lsu_if.awburst = 2'd1; lsu_if.awvalid = 1'b0; lsu_if.wdata = '0; lsu_if.wstrb = '0;
        lsu_if.wlast = 1'b1; lsu_if.wvalid = 1'b0; lsu_if.bready = 1'b1;
        out_if.rresp = '0; out_if.bresp = '0;
        sl_rd = 1'b0; sl_wr = 1'b0; sl_block = 1'b0; sl_bcnt = 0; sl_addr = '0;
        apply_slave();

        vecs[0] = mk(1, 1, 0, 2, 1, 0, 0, 0, 0, 0);
        vecs[1] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(0, 0, 1, 1, 2, 0, 0, 0, 0, 0);
        vecs[3] = mk(1, 0, 1, 2, 0, 2, 0, 0, 0, 0);
        vecs[4] = mk(1, 1, 1, 3, 0, 1, 2, 0, 0, 0);
        vecs[5] = mk(0, 1, 1, 2, 1, 2, 0, 0, 0, 0);
        vecs[6] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(3, 3, 0, 6, 1, 0, 1, 0, 1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'({out_if.arvalid, out_if.awvalid, out_if.wvalid,
                                     out_if.rready, out_if.bready}), 0);
        check("rst_m_ready", 32'({ifu_if.arready, lsu_if.arready, lsu_if.awready,
                                   lsu_if.wready, ifu_if.rvalid, lsu_if.rvalid}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", 32'({out_if.arvalid, out_if.awvalid, out_if.wvalid,
                                      out_if.rready, out_if.bready}), 0);

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        // Write in flight, IFU read arrives mid-way and must wait for B.
        glog.delete();
        push_write();
        repeat (3) tick();
        ifu_q.push_back(32'h3000_0000);
        run_until_idle();
        check("wr_pend_n", glog.size(), 2);
        if (glog.size() == 2) begin
            check("wr_pend_first", glog[0].code, 2);
            check("wr_pend_second", glog[1].code, 0);
            check("wr_pend_bubble", glog[1].gap, 2);
        end

        // Asynchronous reset while the IFU read is presented and stalled.
        sl_block = 1'b1;
        ifu_q.push_back(32'h3000_0000);
        for (int i = 0; i < 10 && !out_if.arvalid; i++) tick();
        check("mid_arvalid_before", 32'(out_if.arvalid), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_arvalid", 32'(out_if.arvalid), 0);
        check("mid_rst_rready", 32'(out_if.rready), 0);
        check("mid_rst_arready", 32'(ifu_if.arready), 0);
        ifu_if.arvalid = 1'b0;
        ifu_busy = 1'b0;
        ifu_exp.delete();
        sl_block = 1'b0; sl_rd = 1'b0; sl_wr = 1'b0; sl_bcnt = 0;
        apply_slave();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_vec(vecs[0]);

        check("sb_empty", 32'(ifu_exp.size() + lsu_exp.size() + aw_exp.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
